reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset release controller that consumes the board-level reset and drives ordered, per-domain active-low resets to downstream logic (PLL-clocked cores, memory controller, peripherals). Reset assertion reaches every stage asynchronously; release is synchronous and staggered by a fixed hold interval, lowest stage first. A level-based software reset request with a req/ack handshake re-asserts the stages in reverse order and then replays the release sequence.

## Interface
Parameters:
- NUM_STAGES, 4, number of downstream reset stages (≥1)
- HOLD_CYCLES, 16, clock cycles between successive stage releases (≥1)

Ports:
- clock  input  1  system clock
- asynch_reset_n  input  1  reset, asynchronous, active-low
- soft_req  input  1  software reset request, level, synchronous to clock
- soft_ack  output  1  software reset acknowledge, high while all stages are held by soft reset
- stage_reset_n  output  NUM_STAGES  per-stage active-low reset; bit 0 released first
- all_ready  output  1  high when every stage is released

## Operation
- asynch_reset_n low: all stage_reset_n = 0, all_ready = 0, soft_ack = 0, FSM = HOLD, counter = 0. Effect is immediate, with no clock required.
- Release front end: a 2-flop release synchronizer clears asynchronously and sets synchronously. It produces rel_ok. The FSM leaves HOLD only while rel_ok = 1.
- FSM states (enum in package):
  - HOLD: all stages asserted. Counter increments while rel_ok. When the counter reaches HOLD_CYCLES, release stage 0, clear the counter, and go to RELEASE.
  - RELEASE: when the counter reaches HOLD_CYCLES, release the next stage and clear the counter. On the edge that releases stage NUM_STAGES-1, set all_ready and go to RUN.
  - RUN: all stages released. soft_req = 1 sampled → go to DRAIN and drop all_ready.
  - DRAIN: assert one stage per cycle, from highest to lowest (stage NUM_STAGES-1 first). After stage 0 is asserted, go to ACK.
  - ACK: soft_ack = 1 and all stages asserted. soft_req = 0 sampled → soft_ack = 0, clear the counter, go to HOLD.
- soft_req is ignored in HOLD, RELEASE and DRAIN. Because it is a level signal, a request still held on entry to RUN is taken on the first RUN edge.
- Stage outputs are registered. A released stage never glitches low except through asynch_reset_n or DRAIN.
- Counter width is $clog2(HOLD_CYCLES+1). It saturates and never wraps.

## Timing
- Let E be the first posedge at which asynch_reset_n is sampled high. rel_ok rises at E+1.
- stage_reset_n[i] rises at edge E+1+(i+1)·HOLD_CYCLES. With the defaults: stage 0 at E+17, stage 3 at E+65.
- all_ready rises on the same edge as stage NUM_STAGES-1.
- Soft reset, with soft_req first sampled high in RUN at edge S:
  - all_ready falls at S.
  - stage NUM_STAGES-1-k falls at S+k, for k = 0..NUM_STAGES-1.
  - soft_ack rises at S+NUM_STAGES.
- Soft reset exit, with soft_req sampled low in ACK at edge T:
  - soft_ack falls at T.
  - stage i rises at T+(i+1)·HOLD_CYCLES. No synchronizer delay applies, because rel_ok is already high.
- asynch_reset_n asserted mid-RELEASE, DRAIN or ACK: full reset. Partial progress is discarded and the sequence restarts from E.
- A pulse on asynch_reset_n shorter than one clock period still clears all state. Release timing restarts from the rising edge.

## Structure
- Package reset_seq_pkg holds the state enum typedef (HOLD, RELEASE, RUN, DRAIN, ACK) and the stage-index width function.
- Sub-module reset_release_sync is the 2-flop release synchronizer producing rel_ok. It takes clock and asynch_reset_n.
- Top level contains the FSM, hold counter, stage index register and output registers.

## Test plan
- Power-up, NUM_STAGES=4, HOLD_CYCLES=16: release asynch_reset_n → stages rise at E+17/33/49/65, and all_ready rises at E+65.
- Soft reset: hold soft_req high in RUN at S → stages fall at S (bit 3) through S+3 (bit 0), and soft_ack rises at S+4.
- Soft reset exit: drop soft_req at T, 20 cycles later → soft_ack falls at T, and stages rise at T+16/32/48/64.
- soft_req raised at E+30 (mid-RELEASE) and held → ignored until RUN at E+65, then DRAIN starts at E+66.
- asynch_reset_n pulsed low for half a cycle while stage 1 is released → all outputs go to 0 immediately, and full power-up timing replays from the new E.
- NUM_STAGES=1, HOLD_CYCLES=1 corner: stage 0 and all_ready rise at E+2; soft req at S → soft_ack at S+1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer: FSM state encoding and the
// width helper for the stage index register.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    RUN,
    DRAIN,
    ACK
  } state_t;

  // A single-stage sequencer still needs a 1-bit index register.
  function automatic int stage_idx_w(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/reset_release_sync.sv
// Two-flop reset release synchronizer: clears asynchronously with
// asynch_reset_n and releases rel_ok on the second clock edge afterwards.
module reset_release_sync (
  input  logic clock,
  input  logic asynch_reset_n,
  output logic rel_ok
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge clock or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rel_ok = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release controller: releases per-domain resets lowest stage
// first, spaced HOLD_CYCLES apart, and replays the sequence on soft reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  asynch_reset_n,
  input  logic                  soft_req,
  output logic                  soft_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  all_ready,
  output state_t                dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = stage_idx_w(NUM_STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  rel_ok;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  hold_done;

  reset_release_sync u_sync (
    .clock          (clock),
    .asynch_reset_n (asynch_reset_n),
    .rel_ok         (rel_ok)
  );

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign hold_done = (cnt_q == CNT_LAST);

  // soft_req/soft_ack: soft_req is a level request sampled only in RUN and ACK;
  // soft_ack rises once every stage is held and stays high until soft_req is
  // seen low, which starts the release replay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    ack_d   = ack_q;
    case (state_q)
      HOLD, RELEASE: begin
        if (rel_ok) begin
          if (hold_done) begin
            cnt_d          = '0;
            stage_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RUN: begin
        if (soft_req) begin
          ready_d = 1'b0;
          stage_d = stage_q >> 1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Released stages form a contiguous low-order run, so shifting
        // right asserts the highest released stage each cycle.
        if (stage_q == '0) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          stage_d = stage_q >> 1;
        end
      end
      ACK: begin
        if (!soft_req) begin
          ack_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge asynch_reset_n) begin
    if (!asynch_reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign stage_reset_n = stage_q;
  assign all_ready     = ready_q;
  assign soft_ack      = ack_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: an event-time model (release base edge, drain
// start edge) predicts every output each cycle, plus directed literal checks.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N0 = 4;
  localparam int H0 = 16;
  localparam int N1 = 1;
  localparam int H1 = 1;

  logic clock  = 1'b0;
  logic rst0_n = 1'b1;
  logic rst1_n = 1'b1;
  logic req0   = 1'b0;
  logic req1   = 1'b0;

  logic          ack0, ack1, ready0, ready1;
  logic [N0-1:0] stage0;
  logic [N1-1:0] stage1;
  state_t        dbg0, dbg1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reset_sequencer #(.NUM_STAGES(N0), .HOLD_CYCLES(H0)) dut0 (
    .clock          (clock),
    .asynch_reset_n (rst0_n),
    .soft_req       (req0),
    .soft_ack       (ack0),
    .stage_reset_n  (stage0),
    .all_ready      (ready0),
    .dbg_state      (dbg0)
  );

  reset_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1)) dut1 (
    .clock          (clock),
    .asynch_reset_n (rst1_n),
    .soft_req       (req1),
    .soft_ack       (ack1),
    .stage_reset_n  (stage1),
    .all_ready      (ready1),
    .dbg_state      (dbg1)
  );

  // ---------------- behavioural model ----------------
  // rel_base: stage i is released from edge rel_base+(i+1)*H onwards.
  // s_edge  : edge at which a soft request was accepted (-1 when none).
  int cyc = 0;
  int rel_base[2] = '{-1, -1};
  int s_edge[2]   = '{-1, -1};
  int seen[2]     = '{0, 0};
  int rst_cnt0 = 0;
  int rst_cnt1 = 0;

  always @(negedge rst0_n) rst_cnt0++;
  always @(negedge rst1_n) rst_cnt1++;

  function automatic int n_of(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic int h_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  // Number of released stages (always the low-order ones) after edge n.
  function automatic int up_count(input int d, input int n);
    int c;
    if (rel_base[d] < 0) return 0;
    if (s_edge[d] >= 0) begin
      c = s_edge[d] + n_of(d) - 1 - n;
    end else begin
      if (n < rel_base[d]) return 0;
      c = (n - rel_base[d]) / h_of(d);
    end
    if (c < 0) c = 0;
    if (c > n_of(d)) c = n_of(d);
    return c;
  endfunction

  task automatic model_step(input int d, input logic rst_n, input int rcnt, input logic req);
    if (!rst_n || rcnt != seen[d]) begin
      rel_base[d] = -1;
      s_edge[d]   = -1;
      seen[d]     = rcnt;
    end
    if (rst_n) begin
      if (rel_base[d] < 0) begin
        rel_base[d] = cyc + 1;
      end else if (s_edge[d] < 0 && up_count(d, cyc - 1) == n_of(d) && req) begin
        s_edge[d] = cyc;
      end else if (s_edge[d] >= 0 && cyc - 1 >= s_edge[d] + n_of(d) && !req) begin
        rel_base[d] = cyc;
        s_edge[d]   = -1;
      end
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    model_step(0, rst0_n, rst_cnt0, req0);
    model_step(1, rst1_n, rst_cnt1, req1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    int c, e_stage, e_ready, e_ack;
    logic rn;
    int rc;
    forever begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        rn = (d == 0) ? rst0_n : rst1_n;
        rc = (d == 0) ? rst_cnt0 : rst_cnt1;
        if (!rn || rc != seen[d]) begin
          e_stage = 0; e_ready = 0; e_ack = 0;
        end else begin
          c       = up_count(d, cyc);
          e_stage = (1 << c) - 1;
          e_ready = (s_edge[d] < 0 && c == n_of(d)) ? 1 : 0;
          e_ack   = (s_edge[d] >= 0 && cyc >= s_edge[d] + n_of(d)) ? 1 : 0;
        end
        if (d == 0) begin
          chk("model stage0", int'(stage0), e_stage);
          chk("model ready0", int'(ready0), e_ready);
          chk("model ack0", int'(ack0), e_ack);
        end else begin
          chk("model stage1", int'(stage1), e_stage);
          chk("model ready1", int'(ready1), e_ready);
          chk("model ack1", int'(ack1), e_ack);
        end
      end
    end
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    fork
      compare_loop();
    join_none
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    #1;
    chk("reset stage0", int'(stage0), 0);
    chk("reset ready0", int'(ready0), 0);
    chk("reset ack0", int'(ack0), 0);
    repeat (3) @(negedge clock);

    // Single stage, single hold cycle corner
    rst1_n = 1'b1;
    edges(1);                                   // E
    chk("c1 E stage", int'(stage1), 0);
    edges(1);                                   // E+1
    chk("c1 E+1 stage", int'(stage1), 0);
    edges(1);                                   // E+2
    chk("c1 E+2 stage", int'(stage1), 1);
    chk("c1 E+2 ready", int'(ready1), 1);
    chk("c1 E+2 state", int'(dbg1), int'(RUN));
    @(negedge clock) req1 = 1'b1;
    edges(1);                                   // S
    chk("c1 S stage", int'(stage1), 0);
    chk("c1 S ready", int'(ready1), 0);
    chk("c1 S ack", int'(ack1), 0);
    edges(1);                                   // S+1
    chk("c1 S+1 ack", int'(ack1), 1);
    repeat (3) @(negedge clock);
    req1 = 1'b0;
    edges(1);                                   // T
    chk("c1 T ack", int'(ack1), 0);
    edges(1);                                   // T+1
    chk("c1 T+1 stage", int'(stage1), 1);
    chk("c1 T+1 ready", int'(ready1), 1);

    // Power-up, four stages, hold 16
    @(negedge clock) rst0_n = 1'b1;
    edges(1);                                   // E
    edges(16);
    chk("pu E+16 stage", int'(stage0), 0);
    edges(1);
    chk("pu E+17 stage", int'(stage0), 1);
    edges(16);
    chk("pu E+33 stage", int'(stage0), 3);
    edges(16);
    chk("pu E+49 stage", int'(stage0), 7);
    edges(15);
    chk("pu E+64 stage", int'(stage0), 7);
    chk("pu E+64 ready", int'(ready0), 0);
    edges(1);
    chk("pu E+65 stage", int'(stage0), 15);
    chk("pu E+65 ready", int'(ready0), 1);
    chk("pu E+65 state", int'(dbg0), int'(RUN));

    // Soft reset drain
    edges(3);
    @(negedge clock) req0 = 1'b1;
    edges(1);                                   // S
    chk("sr S stage", int'(stage0), 7);
    chk("sr S ready", int'(ready0), 0);
    edges(3);
    chk("sr S+3 stage", int'(stage0), 0);
    chk("sr S+3 ack", int'(ack0), 0);
    edges(1);
    chk("sr S+4 ack", int'(ack0), 1);
    chk("sr S+4 state", int'(dbg0), int'(ACK));

    // Soft reset exit
    edges(20);
    @(negedge clock) req0 = 1'b0;
    edges(1);                                   // T
    chk("sx T ack", int'(ack0), 0);
    chk("sx T stage", int'(stage0), 0);
    edges(15);
    chk("sx T+15 stage", int'(stage0), 0);
    edges(1);
    chk("sx T+16 stage", int'(stage0), 1);
    edges(16);
    chk("sx T+32 stage", int'(stage0), 3);
    edges(16);
    chk("sx T+48 stage", int'(stage0), 7);
    edges(16);
    chk("sx T+64 stage", int'(stage0), 15);
    chk("sx T+64 ready", int'(ready0), 1);

    // Short reset pulse between edges, then replay with an early soft request
    edges(2);
    rst0_n = 1'b0;
    #1;
    chk("pulse stage", int'(stage0), 0);
    chk("pulse ready", int'(ready0), 0);
    chk("pulse ack", int'(ack0), 0);
    #1;
    rst0_n = 1'b1;
    edges(1);                                   // E'
    chk("rp E stage", int'(stage0), 0);
    edges(29);
    @(negedge clock) req0 = 1'b1;               // first sampled at E'+30
    edges(35);
    chk("rp E+64 stage", int'(stage0), 7);
    chk("rp E+64 ready", int'(ready0), 0);
    edges(1);
    chk("rp E+65 stage", int'(stage0), 15);
    chk("rp E+65 ready", int'(ready0), 1);
    edges(1);
    chk("rp E+66 stage", int'(stage0), 7);
    chk("rp E+66 ready", int'(ready0), 0);
    edges(3);
    chk("rp E+69 stage", int'(stage0), 0);
    edges(1);
    chk("rp E+70 ack", int'(ack0), 1);
    @(negedge clock) req0 = 1'b0;
    edges(1);
    chk("rp T ack", int'(ack0), 0);
    edges(64);
    chk("rp T+64 stage", int'(stage0), 15);
    chk("rp T+64 ready", int'(ready0), 1);
    edges(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
